sad_min_search: RTL and testbench



---
 rtl/sad_min_search_if.sv | 41 ++++
 rtl/sad_min_search.sv | 174 +++++++++++++++++
 tb/tb_sad_min_search.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sad_min_search_if.sv
// ----------------------------------------------------------------------------
// sad_min_search_if
// Bundles the control and data signals of sad_min_search.
//   start        : begin a search (driven by master)
//   ad_valid     : ad_bus carries a beat of per-PE absolute differences
//   ad_bus       : N_PE lanes of AD_W bits, lane i at [i*AD_W +: AD_W]
//   busy         : search in progress (RUN/FLUSH/DONE)
//   result_valid : one-cycle pulse, best_* valid
//   best_sad/x/y : minimum SAD and its candidate coordinates
// master = producer of start/beats, slave = the search block.
// ----------------------------------------------------------------------------
interface sad_min_search_if #(
    parameter int N_PE       = 16,
    parameter int AD_W       = 8,
    parameter int BLOCK_ROWS = 16,
    parameter int SEARCH_W   = 8,
    parameter int SEARCH_H   = 8
);
    localparam int SAD_W = AD_W + $clog2(N_PE) + $clog2(BLOCK_ROWS);
    localparam int XW    = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1;
    localparam int YW    = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;

    logic                 start;
    logic                 ad_valid;
    logic [N_PE*AD_W-1:0] ad_bus;
    logic                 busy;
    logic                 result_valid;
    logic [SAD_W-1:0]     best_sad;
    logic [XW-1:0]        best_x;
    logic [YW-1:0]        best_y;

    modport master (
        output start, ad_valid, ad_bus,
        input  busy, result_valid, best_sad, best_x, best_y
    );

    modport slave (
        input  start, ad_valid, ad_bus,
        output busy, result_valid, best_sad, best_x, best_y
    );
endinterface

// File: rtl/sad_min_search.sv
// ----------------------------------------------------------------------------
// sad_min_search
// Sums per-PE absolute differences of each beat into a row SAD, accumulates
// BLOCK_ROWS rows into a candidate SAD and tracks the minimum SAD with its
// (x, y) over a raster-ordered SEARCH_W x SEARCH_H window.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   bus_if : sad_min_search_if.slave (start, ad_valid, ad_bus in;
//            busy, result_valid, best_sad, best_x, best_y out)
// Pipeline: beat -> row-sum register -> accumulate/compare register.
// ----------------------------------------------------------------------------
module sad_min_search #(
    parameter int N_PE       = 16,
    parameter int AD_W       = 8,
    parameter int BLOCK_ROWS = 16,
    parameter int SEARCH_W   = 8,
    parameter int SEARCH_H   = 8
) (
    input  logic               clk,
    input  logic               rst,
    sad_min_search_if.slave    bus_if
);
    localparam int SAD_W = AD_W + $clog2(N_PE) + $clog2(BLOCK_ROWS);
    localparam int XW    = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1;
    localparam int YW    = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;
    localparam int RW    = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic             r_flush_cnt;
    logic [RW-1:0]    r_row;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    // row-sum stage
    logic             r_rs_vld;
    logic             r_rs_last;
    logic [SAD_W-1:0] r_rs_sum;
    logic [XW-1:0]    r_rs_x;
    logic [YW-1:0]    r_rs_y;
    // accumulate / compare stage
    logic [SAD_W-1:0] r_acc;
    logic [SAD_W-1:0] r_min;
    logic [XW-1:0]    r_min_x;
    logic [YW-1:0]    r_min_y;
    // outputs
    logic             r_result_valid;
    logic [SAD_W-1:0] r_best_sad;
    logic [XW-1:0]    r_best_x;
    logic [YW-1:0]    r_best_y;

    logic             w_beat;
    logic             w_row_wrap;
    logic             w_x_wrap;
    logic             w_y_wrap;
    logic [SAD_W-1:0] w_lane_sum;
    logic [SAD_W-1:0] w_cand;

    assign w_beat     = (r_state == S_RUN) && bus_if.ad_valid;
    assign w_row_wrap = (r_row == RW'(BLOCK_ROWS - 1));
    assign w_x_wrap   = (r_x == XW'(SEARCH_W - 1));
    assign w_y_wrap   = (r_y == YW'(SEARCH_H - 1));
    assign w_cand     = r_acc + r_rs_sum;

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < N_PE; i++)
            w_lane_sum = w_lane_sum + SAD_W'(bus_if.ad_bus[i*AD_W +: AD_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_flush_cnt    <= 1'b0;
            r_row          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_rs_vld       <= 1'b0;
            r_rs_last      <= 1'b0;
            r_rs_sum       <= '0;
            r_rs_x         <= '0;
            r_rs_y         <= '0;
            r_acc          <= '0;
            r_min          <= '0;
            r_min_x        <= '0;
            r_min_y        <= '0;
            r_result_valid <= 1'b0;
            r_best_sad     <= '0;
            r_best_x       <= '0;
            r_best_y       <= '0;
        end else begin
            r_result_valid <= 1'b0;

            // Row-sum stage: carry the candidate coordinates along with the
            // sum so the compare stage never needs the (already advanced)
            // live counters.
            r_rs_vld <= w_beat;
            if (w_beat) begin
                r_rs_sum  <= w_lane_sum;
                r_rs_last <= w_row_wrap;
                r_rs_x    <= r_x;
                r_rs_y    <= r_y;
                r_row     <= w_row_wrap ? '0 : r_row + RW'(1);
                if (w_row_wrap) begin
                    r_x <= w_x_wrap ? '0 : r_x + XW'(1);
                    if (w_x_wrap)
                        r_y <= w_y_wrap ? '0 : r_y + YW'(1);
                end
            end

            // Accumulate stage; on the last row the sum is final, so it is
            // compared here and the accumulator restarts for the next
            // candidate without a bubble. Strict < keeps the raster-earlier
            // candidate on ties.
            if (r_rs_vld) begin
                if (r_rs_last) begin
                    r_acc <= '0;
                    if (w_cand < r_min) begin
                        r_min   <= w_cand;
                        r_min_x <= r_rs_x;
                        r_min_y <= r_rs_y;
                    end
                end else begin
                    r_acc <= w_cand;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus_if.start) begin
                        r_state <= S_RUN;
                        r_row   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_acc   <= '0;
                        r_min   <= '1;
                        r_min_x <= '0;
                        r_min_y <= '0;
                    end
                end
                S_RUN: begin
                    if (w_beat && w_row_wrap && w_x_wrap && w_y_wrap) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= 1'b1;
                    // Results are loaded on the edge entering DONE so they
                    // are already stable while result_valid is high.
                    if (r_flush_cnt) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                        r_best_sad     <= r_min;
                        r_best_x       <= r_min_x;
                        r_best_y       <= r_min_y;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_if.busy         = (r_state != S_IDLE);
    assign bus_if.result_valid = r_result_valid;
    assign bus_if.best_sad     = r_best_sad;
    assign bus_if.best_x       = r_best_x;
    assign bus_if.best_y       = r_best_y;

endmodule

// File: tb/tb_sad_min_search.sv
// ----------------------------------------------------------------------------
// tb_sad_min_search
// Directed, table-driven bench. dut_a uses a small 3x2 window (N_PE=4,
// BLOCK_ROWS=2) for the functional vectors; dut_b uses the default
// parameters for the full-scale width check.
// ----------------------------------------------------------------------------
module tb_sad_min_search;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_min_search_if #(.N_PE(4), .AD_W(8), .BLOCK_ROWS(2), .SEARCH_W(3), .SEARCH_H(2)) ifa();
    sad_min_search #(.N_PE(4), .AD_W(8), .BLOCK_ROWS(2), .SEARCH_W(3), .SEARCH_H(2)) dut_a (
        .clk(clk), .rst(rst), .bus_if(ifa)
    );

    sad_min_search_if ifb();
    sad_min_search dut_b (.clk(clk), .rst(rst), .bus_if(ifb));

    int errors = 0;
    int checks = 0;

    typedef struct {
        string            name;
        logic [5:0][31:0] cand;     // per-candidate beat (same for both rows), raster order
        bit               bubbles;
        int               exp_sad;
        int               exp_x;
        int               exp_y;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input string name);
        ifa.start = 1'b1;
        tick;
        ifa.start = 1'b0;
        check({name, " busy after start"}, 32'(ifa.busy), 1);
    endtask

    task automatic stream_a(input logic [5:0][31:0] cand, input bit bubbles);
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (bubbles) begin
                    int nb;
                    nb = $urandom_range(0, 2);
                    repeat (nb) begin
                        ifa.ad_valid = 1'b0;
                        ifa.ad_bus   = $urandom;
                        tick;
                    end
                end
                ifa.ad_valid = 1'b1;
                ifa.ad_bus   = cand[c];
                tick;
            end
        end
        ifa.ad_valid = 1'b0;
        ifa.ad_bus   = $urandom;
    endtask

    // Called just after the edge that sampled the last beat.
    task automatic wait_result_a(input string name, input int sad, input int x, input int y);
        int n;
        n = 0;
        while (ifa.result_valid !== 1'b1 && n < 12) begin
            tick;
            n++;
        end
        check({name, " latency"}, 32'(n), 2);
        check({name, " best_sad"}, 32'(ifa.best_sad), 32'(sad));
        check({name, " best_x"}, 32'(ifa.best_x), 32'(x));
        check({name, " best_y"}, 32'(ifa.best_y), 32'(y));
        tick;
        check({name, " pulse width"}, 32'(ifa.result_valid), 0);
        check({name, " busy idle"}, 32'(ifa.busy), 0);
    endtask

    initial begin
        // uniq: every lane 10 except candidate (1,1) -> 4*2*1 = 8
        vecs[0].name = "uniq"; vecs[0].cand = {6{32'h0A0A0A0A}};
        vecs[0].cand[4] = 32'h01010101; vecs[0].bubbles = 0;
        vecs[0].exp_sad = 8; vecs[0].exp_x = 1; vecs[0].exp_y = 1;
        // tie: (2,0) and (0,1) both 2*(5+5)=20, others 2*20=40
        vecs[1].name = "tie"; vecs[1].cand = {6{32'h05050505}};
        vecs[1].cand[2] = 32'h00000505; vecs[1].cand[3] = 32'h00000505; vecs[1].bubbles = 1;
        vecs[1].exp_sad = 20; vecs[1].exp_x = 2; vecs[1].exp_y = 0;
        // desc: lane value 6-c, last candidate (2,1) wins with 8
        vecs[2].name = "desc";
        for (int c = 0; c < 6; c++) vecs[2].cand[c] = {4{8'(6 - c)}};
        vecs[2].bubbles = 1; vecs[2].exp_sad = 8; vecs[2].exp_x = 2; vecs[2].exp_y = 1;
        // max: 4*2*255 = 2040 everywhere, first candidate kept
        vecs[3].name = "max"; vecs[3].cand = {6{32'hFFFFFFFF}}; vecs[3].bubbles = 0;
        vecs[3].exp_sad = 2040; vecs[3].exp_x = 0; vecs[3].exp_y = 0;
        // top lane only: (2,1) = 2*128 = 256, others 2*255 = 510
        vecs[4].name = "lane3"; vecs[4].cand = {6{32'hFF000000}};
        vecs[4].cand[5] = 32'h80000000; vecs[4].bubbles = 0;
        vecs[4].exp_sad = 256; vecs[4].exp_x = 2; vecs[4].exp_y = 1;

        ifa.start = 1'b0; ifa.ad_valid = 1'b0; ifa.ad_bus = '0;
        ifb.start = 1'b0; ifb.ad_valid = 1'b0; ifb.ad_bus = '0;

        // Reset
        rst = 1'b1;
        tick; tick;
        check("rst busy", 32'(ifa.busy), 0);
        check("rst result_valid", 32'(ifa.result_valid), 0);
        check("rst best_sad", 32'(ifa.best_sad), 0);
        check("rst best_x", 32'(ifa.best_x), 0);
        check("rst best_y", 32'(ifa.best_y), 0);
        check("rst b busy", 32'(ifb.busy), 0);
        check("rst b best_sad", 32'(ifb.best_sad), 0);
        rst = 1'b0;

        // Beats while IDLE must not disturb anything
        ifa.ad_valid = 1'b1; ifa.ad_bus = 32'h01010101;
        repeat (4) tick;
        ifa.ad_valid = 1'b0;
        check("idle beats busy", 32'(ifa.busy), 0);
        check("idle beats result_valid", 32'(ifa.result_valid), 0);

        for (int i = 0; i < 5; i++) begin
            start_a(vecs[i].name);
            stream_a(vecs[i].cand, vecs[i].bubbles);
            wait_result_a(vecs[i].name, vecs[i].exp_sad, vecs[i].exp_x, vecs[i].exp_y);
        end

        // Reset during candidate (1,0): aborted run must not report
        begin
            bit seen;
            seen = 1'b0;
            start_a("abort");
            ifa.ad_valid = 1'b1; ifa.ad_bus = 32'h03030303;
            repeat (3) tick;
            rst = 1'b1;
            tick;
            rst = 1'b0;
            ifa.ad_valid = 1'b0;
            check("abort busy", 32'(ifa.busy), 0);
            check("abort best_sad cleared", 32'(ifa.best_sad), 0);
            repeat (12) begin
                if (ifa.result_valid === 1'b1) seen = 1'b1;
                tick;
            end
            check("abort no result", 32'(seen), 0);
            start_a("zero");
            stream_a({6{32'h00000000}}, 1'b0);
            wait_result_a("zero", 0, 0, 0);
        end

        // Back-to-back with start held high the whole time
        ifa.start = 1'b1;
        tick;
        check("b2b busy", 32'(ifa.busy), 1);
        stream_a(vecs[0].cand, 1'b0);
        wait_result_a("b2b first", 8, 1, 1);
        tick;
        check("b2b restart busy", 32'(ifa.busy), 1);
        stream_a(vecs[1].cand, 1'b1);
        check("b2b hold sad", 32'(ifa.best_sad), 8);
        check("b2b hold x", 32'(ifa.best_x), 1);
        check("b2b hold y", 32'(ifa.best_y), 1);
        wait_result_a("b2b second", 20, 2, 0);
        ifa.start = 1'b0;

        // Full-size window: 16 lanes of 255 over 16 rows = 65280, no wrap
        begin
            int n;
            ifb.start = 1'b1;
            tick;
            ifb.start = 1'b0;
            ifb.ad_valid = 1'b1; ifb.ad_bus = '1;
            repeat (8 * 8 * 16) tick;
            ifb.ad_valid = 1'b0;
            n = 0;
            while (ifb.result_valid !== 1'b1 && n < 12) begin
                tick;
                n++;
            end
            check("sat latency", 32'(n), 2);
            check("sat best_sad", 32'(ifb.best_sad), 65280);
            check("sat best_x", 32'(ifb.best_x), 0);
            check("sat best_y", 32'(ifb.best_y), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
